// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART RX types and constants (FSM state enum, parity sense, default width)
package uart_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/uart_sat_counter.sv
// rtl/uart_sat_counter.sv - saturating event counter with synchronous clear
module uart_sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // Clear wins over increment; increment stops at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/uart_frame_check.sv
// rtl/uart_frame_check.sv - UART RX frame walker: start/parity/stop checks and deserialisation; optional UART_FRAME_ERR_CNT_EN error counters
module uart_frame_check
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sampled_bit,
   input  logic                  sample_valid,
   input  logic                  frame_start,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  stp2_en,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  frm_done,
   output logic                  strt_err,
   output logic                  par_err,
   output logic                  stp_err
`ifdef UART_FRAME_ERR_CNT_EN
   ,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt
`endif
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   // Reject configurations the shift register and counters cannot represent.
   if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (CNT_WIDTH < 1)) begin : g_param_check
      $error("uart_frame_check: DATA_WIDTH must be 5..9 and CNT_WIDTH >= 1");
   end

   state_e                state_q,    state_d;
   logic [BW-1:0]         cnt_q,      cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,    shift_d;
   logic                  acc_q,      acc_d;
   logic                  par_en_q,   par_en_d;
   logic                  par_typ_q,  par_typ_d;
   logic                  stp2_q,     stp2_d;
   logic                  stop1_q,    stop1_d;
   logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
   logic                  frm_done_q, frm_done_d;
   logic                  strt_err_q, strt_err_d;
   logic                  par_err_q,  par_err_d;
   logic                  stp_err_q,  stp_err_d;
   logic                  exp_par;

   // Even parity expects the data XOR itself; odd parity expects its inverse.
   assign exp_par = (par_typ_q == PAR_EVEN) ? acc_q : ~acc_q;

   // Next-state and datapath: every move past START waits for a sample strobe.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      stp2_d     = stp2_q;
      stop1_d    = stop1_q;
      p_data_d   = p_data_q;
      frm_done_d = 1'b0;
      strt_err_d = strt_err_q;
      par_err_d  = par_err_q;
      stp_err_d  = stp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d    = ST_START;
               par_en_d   = par_en;
               par_typ_d  = par_typ;
               stp2_d     = stp2_en;
               stop1_d    = 1'b0;
               strt_err_d = 1'b0;
               par_err_d  = 1'b0;
               stp_err_d  = 1'b0;
               acc_d      = 1'b0;
               cnt_d      = '0;
            end
         end
         ST_START: begin
            if (sample_valid) begin
               if (sampled_bit) begin
                  strt_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (sample_valid) begin
               shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               acc_d   = acc_q ^ sampled_bit;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (sample_valid) begin
               par_err_d = (sampled_bit != exp_par);
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (sample_valid) begin
               stp_err_d = stp_err_q | ~sampled_bit;
               if (!stp2_q || stop1_q) begin
                  p_data_d   = shift_q;
                  frm_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  stop1_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         acc_q      <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stp2_q     <= 1'b0;
         stop1_q    <= 1'b0;
         p_data_q   <= '0;
         frm_done_q <= 1'b0;
         strt_err_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         stp2_q     <= stp2_d;
         stop1_q    <= stop1_d;
         p_data_q   <= p_data_d;
         frm_done_q <= frm_done_d;
         strt_err_q <= strt_err_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
      end
   end

   assign p_data   = p_data_q;
   assign frm_done = frm_done_q;
   assign strt_err = strt_err_q;
   assign par_err  = par_err_q;
   assign stp_err  = stp_err_q;

`ifdef UART_FRAME_ERR_CNT_EN
   // Completed frames only are counted; start-glitch aborts never raise frm_done.
   uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (frm_done_q & par_err_q),
      .clr   (cnt_clr),
      .count (par_err_cnt)
   );

   uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (frm_done_q & stp_err_q),
      .clr   (cnt_clr),
      .count (stp_err_cnt)
   );
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// tb/tb_uart_frame_check.sv - directed self-checking bench for uart_frame_check; counter tests under UART_FRAME_ERR_CNT_EN
module tb_uart_frame_check;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       sampled_bit;
   logic       sample_valid;
   logic       frame_start;
   logic       par_en;
   logic       par_typ;
   logic       stp2_en;
   logic [7:0] p_data;
   logic       frm_done;
   logic       strt_err;
   logic       par_err;
   logic       stp_err;
`ifdef UART_FRAME_ERR_CNT_EN
   logic       cnt_clr;
   logic [1:0] par_err_cnt;
   logic [1:0] stp_err_cnt;
`endif

   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   uart_frame_check #(
      .DATA_WIDTH (8),
      .CNT_WIDTH  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sampled_bit  (sampled_bit),
      .sample_valid (sample_valid),
      .frame_start  (frame_start),
      .par_en       (par_en),
      .par_typ      (par_typ),
      .stp2_en      (stp2_en),
      .p_data       (p_data),
      .frm_done     (frm_done),
      .strt_err     (strt_err),
      .par_err      (par_err),
      .stp_err      (stp_err)
`ifdef UART_FRAME_ERR_CNT_EN
      ,
      .cnt_clr      (cnt_clr),
      .par_err_cnt  (par_err_cnt),
      .stp_err_cnt  (stp_err_cnt)
`endif
   );

   always @(negedge clk) begin
      if (frm_done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic pe, input logic pt, input logic s2);
      frame_start = 1'b1;
      par_en      = pe;
      par_typ     = pt;
      stp2_en     = s2;
      tick();
      frame_start = 1'b0;
      par_en      = ~pe;
      par_typ     = ~pt;
      stp2_en     = ~s2;
   endtask

   task automatic send_bit(input logic b);
      sampled_bit  = b;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic send_body(input logic [7:0] d, input logic pe, input logic pb,
                            input logic s2, input logic st1, input logic st2);
      tick();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         send_bit(d[i]);
      end
      if (pe) begin
         tick();
         send_bit(pb);
      end
      tick();
      send_bit(st1);
      if (s2) begin
         tick();
         send_bit(st2);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                             input logic pb, input logic st1, input logic st2);
      pulse_start(pe, pt, s2);
      send_body(d, pe, pb, s2, st1, st2);
   endtask

   task automatic test_reset();
      tests++; if (p_data !== 8'h00) begin fails++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
      tests++; if (frm_done !== 1'b0) begin fails++; $display("FAIL reset_frm_done: got %b expected 0", frm_done); end
      tests++; if ({strt_err, par_err, stp_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {strt_err, par_err, stp_err}); end
`ifdef UART_FRAME_ERR_CNT_EN
      tests++; if ({par_err_cnt, stp_err_cnt} !== 4'h0) begin fails++; $display("FAIL reset_counters: got %h expected 0", {par_err_cnt, stp_err_cnt}); end
`endif
   endtask

   task automatic test_8n1();
      int d0;
      d0 = done_cnt;
      send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1);
      tests++; if (frm_done !== 1'b1) begin fails++; $display("FAIL 8n1_done: got %b expected 1", frm_done); end
      tests++; if (p_data !== 8'hA5) begin fails++; $display("FAIL 8n1_p_data: got %h expected a5", p_data); end
      tests++; if ({strt_err, par_err, stp_err} !== 3'b000) begin fails++; $display("FAIL 8n1_flags: got %b expected 000", {strt_err, par_err, stp_err}); end
      tick();
      tests++; if (frm_done !== 1'b0) begin fails++; $display("FAIL 8n1_done_width: got %b expected 0", frm_done); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL 8n1_pulses: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_parity();
      send_frame(8'h03, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1);
      tests++; if (frm_done !== 1'b1) begin fails++; $display("FAIL 8e1_done: got %b expected 1", frm_done); end
      tests++; if ({par_err, stp_err} !== 2'b10) begin fails++; $display("FAIL 8e1_flags: got par=%b stp=%b expected par=1 stp=0", par_err, stp_err); end
      tests++; if (p_data !== 8'h03) begin fails++; $display("FAIL 8e1_p_data: got %h expected 03", p_data); end
`ifdef UART_FRAME_ERR_CNT_EN
      tests++; if (par_err_cnt !== 2'd0) begin fails++; $display("FAIL 8e1_cnt_before: got %0d expected 0", par_err_cnt); end
`endif
      tick();
`ifdef UART_FRAME_ERR_CNT_EN
      tests++; if (par_err_cnt !== 2'd1) begin fails++; $display("FAIL 8e1_cnt_after: got %0d expected 1", par_err_cnt); end
`endif
      repeat (3) tick();
      tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL 8e1_flag_hold: got %b expected 1", par_err); end
   endtask

   task automatic test_two_stop();
      int d0;
      d0 = done_cnt;
      send_frame(8'hFF, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b1, 1'b0);
      tests++; if (done_cnt !== d0) begin fails++; $display("FAIL 8o2_early_done: got %0d pulses expected 0", done_cnt - d0); end
      tests++; if (frm_done !== 1'b1) begin fails++; $display("FAIL 8o2_done: got %b expected 1", frm_done); end
      tests++; if ({par_err, stp_err} !== 2'b01) begin fails++; $display("FAIL 8o2_flags: got par=%b stp=%b expected par=0 stp=1", par_err, stp_err); end
      tests++; if (p_data !== 8'hFF) begin fails++; $display("FAIL 8o2_p_data: got %h expected ff", p_data); end
      tick();
      tests++; if (frm_done !== 1'b0) begin fails++; $display("FAIL 8o2_done_width: got %b expected 0", frm_done); end
      d0 = done_cnt;
      send_frame(8'hFF, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b0);
      tests++; if (frm_done !== 1'b1) begin fails++; $display("FAIL 8o1_done: got %b expected 1", frm_done); end
      tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL 8o1_stp_err: got %b expected 0", stp_err); end
      tick();
      send_bit(1'b0);
      repeat (2) tick();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL 8o1_idle_sample: got %0d pulses expected 1", done_cnt - d0); end
      tests++; if (stp_err !== 1'b0) begin fails++; $display("FAIL 8o1_idle_stp_err: got %b expected 0", stp_err); end
   endtask

   task automatic test_start_glitch();
      int d0;
      d0 = done_cnt;
      pulse_start(1'b0, PAR_EVEN, 1'b0);
      tick();
      send_bit(1'b1);
      tests++; if (strt_err !== 1'b1) begin fails++; $display("FAIL glitch_strt_err: got %b expected 1", strt_err); end
      tests++; if (frm_done !== 1'b0) begin fails++; $display("FAIL glitch_done: got %b expected 0", frm_done); end
      for (int i = 0; i < 10; i++) begin
         tick();
         send_bit(i[0]);
      end
      tick();
      tests++; if (done_cnt !== d0) begin fails++; $display("FAIL glitch_idle: got %0d pulses expected 0", done_cnt - d0); end
      pulse_start(1'b0, PAR_EVEN, 1'b0);
      tests++; if (strt_err !== 1'b0) begin fails++; $display("FAIL glitch_clear: got %b expected 0", strt_err); end
      send_body(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tests++; if (p_data !== 8'h5A) begin fails++; $display("FAIL glitch_next_p_data: got %h expected 5a", p_data); end
      tests++; if ({strt_err, par_err, stp_err} !== 3'b000) begin fails++; $display("FAIL glitch_next_flags: got %b expected 000", {strt_err, par_err, stp_err}); end
      tick();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL glitch_next_pulses: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_reset_midframe();
      int d0;
      d0 = done_cnt;
      pulse_start(1'b0, PAR_EVEN, 1'b0);
      tick();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         send_bit(i[1]);
      end
      rst = 1'b0;
      #2;
      tests++; if (p_data !== 8'h00) begin fails++; $display("FAIL midrst_p_data: got %h expected 00", p_data); end
      tests++; if ({frm_done, strt_err, par_err, stp_err} !== 4'h0) begin fails++; $display("FAIL midrst_flags: got %b expected 0000", {frm_done, strt_err, par_err, stp_err}); end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1);
      tests++; if (p_data !== 8'h3C) begin fails++; $display("FAIL midrst_next_p_data: got %h expected 3c", p_data); end
      tests++; if ({strt_err, par_err, stp_err} !== 3'b000) begin fails++; $display("FAIL midrst_next_flags: got %b expected 000", {strt_err, par_err, stp_err}); end
      tick();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL midrst_pulses: got %0d expected 1", done_cnt - d0); end
   endtask

`ifdef UART_FRAME_ERR_CNT_EN
   task automatic test_counters();
      int exp_cnt;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat (2) tick();
         exp_cnt = (k > 3) ? 3 : k;
         tests++; if (stp_err_cnt !== 2'(exp_cnt)) begin fails++; $display("FAIL cnt_sat_%0d: got %0d expected %0d", k, stp_err_cnt, exp_cnt); end
      end
      tests++; if (par_err_cnt !== 2'd0) begin fails++; $display("FAIL cnt_par_idle: got %0d expected 0", par_err_cnt); end
      send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      tick();
      tests++; if (stp_err_cnt !== 2'd0) begin fails++; $display("FAIL cnt_clr_priority: got %0d expected 0", stp_err_cnt); end
   endtask
`endif

   initial begin
      rst          = 1'b0;
      sampled_bit  = 1'b1;
      sample_valid = 1'b0;
      frame_start  = 1'b0;
      par_en       = 1'b0;
      par_typ      = 1'b0;
      stp2_en      = 1'b0;
`ifdef UART_FRAME_ERR_CNT_EN
      cnt_clr      = 1'b0;
`endif
      repeat (2) tick();
      test_reset();
      rst = 1'b1;
      tick();
      test_8n1();
      test_parity();
      test_two_stop();
      test_start_glitch();
      test_reset_midframe();
`ifdef UART_FRAME_ERR_CNT_EN
      test_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
